// File: rtl/riscv_pkg.sv
// Shared constants for the multicycle RV64-subset core: opcodes, funct codes,
// FSM states, ALU operation encoding and instruction-legality helpers.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LD_SD   = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } alu_op_e;

  function automatic logic is_legal(input logic [31:0] ir);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ir[14:12];
    f7 = ir[31:25];
    case (ir[6:0])
      OP_R:              is_legal = ((f7 == F7_BASE) && (f3 inside {F3_ADD_SUB, F3_AND, F3_OR})) ||
                                    ((f7 == F7_SUB) && (f3 == F3_ADD_SUB));
      OP_IMM:            is_legal = (f3 == F3_ADD_SUB);
      OP_LOAD, OP_STORE: is_legal = (f3 == F3_LD_SD);
      OP_BRANCH:         is_legal = f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE};
      default:           is_legal = 1'b0;
    endcase
  endfunction

  // Only R-type selects a non-add operation; address and addi math all add.
  function automatic alu_op_e decode_alu_op(input logic [31:0] ir);
    decode_alu_op = ALU_ADD;
    if (ir[6:0] == OP_R) begin
      if (ir[14:12] == F3_AND)      decode_alu_op = ALU_AND;
      else if (ir[14:12] == F3_OR)  decode_alu_op = ALU_OR;
      else if (ir[31:25] == F7_SUB) decode_alu_op = ALU_SUB;
    end
  endfunction

endpackage

// File: rtl/riscv_regfile_nr.sv
// NUM_REGS x XLEN register file: two combinational read ports, a debug read
// port and one synchronous write port; x0 always reads zero.
module riscv_regfile_nr
  import riscv_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NUM_REGS = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  input  logic [AW-1:0]   dbg_addr_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  output logic [XLEN-1:0] dbg_data_o
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o   = (raddr1_i   == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o   = (raddr2_i   == '0) ? '0 : regs_q[raddr2_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV64-subset core: FETCH/DECODE/EXEC/MEM/WB sequencing with
// request/valid handshakes so either memory may insert wait states.
module riscv_multicycle_core
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              NUM_REGS = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_valid,
  output logic [XLEN-1:0] pc_out,
  output logic            retire,
  output logic            halted,
  input  logic [4:0]      dbg_sel,
  output logic [XLEN-1:0] dbg_data
);

  localparam int AW = $clog2(NUM_REGS);

  state_e          state_q;
  alu_op_e         alu_op_q;
  logic [XLEN-1:0] pc_q, a_q, b_q, imm_q, aluout_q, mdr_q;
  logic [31:0]     ir_q;
  logic            retire_q, halted_q;

  logic [6:0]      opcode;
  logic [XLEN-1:0] rs1_data, rs2_data, imm_d, op_b, alu_res_d, pc_plus4, wb_data;
  logic            taken_d, is_store, rf_we;

  assign opcode   = ir_q[6:0];
  assign is_store = (opcode == OP_STORE);
  assign pc_plus4 = pc_q + XLEN'(4);
  assign op_b     = (opcode == OP_R) ? b_q : imm_q;
  assign rf_we    = (state_q == S_WB);
  assign wb_data  = (opcode == OP_LOAD) ? mdr_q : aluout_q;

  riscv_regfile_nr #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk_i      (clk),
    .rst_ni     (reset),
    .we_i       (rf_we),
    .waddr_i    (ir_q[7 +: AW]),
    .wdata_i    (wb_data),
    .raddr1_i   (ir_q[15 +: AW]),
    .raddr2_i   (ir_q[20 +: AW]),
    .dbg_addr_i (dbg_sel[AW-1:0]),
    .rdata1_o   (rs1_data),
    .rdata2_o   (rs2_data),
    .dbg_data_o (dbg_data)
  );

  // B-immediate already carries its zero LSB, so branch targets add it directly.
  always_comb begin
    imm_d = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    case (opcode)
      OP_STORE:  imm_d = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OP_BRANCH: imm_d = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      default:   ;
    endcase
  end

  always_comb begin
    alu_res_d = a_q + op_b;
    case (alu_op_q)
      ALU_SUB: alu_res_d = a_q - op_b;
      ALU_AND: alu_res_d = a_q & op_b;
      ALU_OR:  alu_res_d = a_q | op_b;
      default: ;
    endcase
  end

  always_comb begin
    taken_d = 1'b0;
    case (ir_q[14:12])
      F3_BEQ:  taken_d = (a_q == b_q);
      F3_BNE:  taken_d = (a_q != b_q);
      F3_BLT:  taken_d = ($signed(a_q) <  $signed(b_q));
      F3_BGE:  taken_d = ($signed(a_q) >= $signed(b_q));
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= PC_RESET;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      alu_op_q <= ALU_ADD;
      aluout_q <= '0;
      mdr_q    <= '0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (imem_valid) begin
            ir_q    <= imem_rdata;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q      <= rs1_data;
          b_q      <= rs2_data;
          imm_q    <= imm_d;
          alu_op_q <= decode_alu_op(ir_q);
          if (is_legal(ir_q)) begin
            state_q <= S_EXEC;
          end else begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end
        end
        S_EXEC: begin
          aluout_q <= alu_res_d;
          if (opcode == OP_BRANCH) begin
            pc_q     <= taken_d ? (pc_q + imm_q) : pc_plus4;
            retire_q <= 1'b1;
            state_q  <= S_FETCH;
          end else if ((opcode == OP_LOAD) || is_store) begin
            state_q <= S_MEM;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_valid) begin
            if (is_store) begin
              pc_q     <= pc_plus4;
              retire_q <= 1'b1;
              state_q  <= S_FETCH;
            end else begin
              mdr_q   <= dmem_rdata;
              state_q <= S_WB;
            end
          end
        end
        S_WB: begin
          pc_q     <= pc_plus4;
          retire_q <= 1'b1;
          state_q  <= S_FETCH;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  // Requests are qualified by reset so they drop the instant reset asserts.
  assign imem_req   = reset && (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = reset && (state_q == S_MEM);
  assign dmem_we    = dmem_req && is_store;
  assign dmem_addr  = aluout_q;
  assign dmem_wdata = b_q;
  assign pc_out     = pc_q;
  assign retire     = retire_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Self-checking bench for riscv_multicycle_core: behavioural memories with
// programmable wait states and a scoreboard of expected retire PCs/latencies.
module tb_riscv_multicycle_core;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_valid, dmem_req, dmem_we, dmem_valid, retire, halted;
  logic [63:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc_out, dbg_data;
  logic [31:0] imem_rdata;
  logic [4:0]  dbg_sel = 5'd0;

  logic [31:0] imem [256];
  logic [63:0] dmem [256];
  int imem_delay = 0, dmem_delay = 0, imem_cnt = 0, dmem_cnt = 0;
  int store_count = 0, hold_err = 0;
  logic [63:0] last_st_addr = '0, last_st_data = '0;
  logic        i_pend = 1'b0, d_pend = 1'b0, d_pwe = 1'b0;
  logic [63:0] i_paddr = '0, d_paddr = '0, d_pdata = '0;

  int tests_run = 0, tests_failed = 0;

  typedef struct { logic [63:0] pc; int lat; } ret_t;
  typedef struct { int idx; logic [63:0] val; } reg_t;
  ret_t exp_q [$];
  reg_t reg_q [$];

  int br_f3  [4] = '{0, 1, 4, 5};
  int br_rs1 [4] = '{1, 1, 2, 2};
  int br_rs2 [4] = '{1, 1, 1, 1};
  int br_imm [4] = '{8, 8, -16, 8};
  logic [63:0] br_tgt [4] = '{64'h18, 64'h14, 64'h00, 64'h14};

  always #5 clk = ~clk;

  riscv_multicycle_core #(.XLEN(64), .NUM_REGS(32), .PC_RESET(64'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_valid (dmem_valid),
    .pc_out     (pc_out),
    .retire     (retire),
    .halted     (halted),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  assign imem_rdata = imem[imem_addr[9:2]];
  assign dmem_rdata = dmem[dmem_addr[10:3]];
  assign imem_valid = imem_req && (imem_cnt == imem_delay);
  assign dmem_valid = dmem_req && (dmem_cnt == dmem_delay);

  // Memory model: counts wait cycles per pending request and commits stores on accept.
  always @(posedge clk) begin
    imem_cnt <= (imem_req && !imem_valid) ? imem_cnt + 1 : 0;
    dmem_cnt <= (dmem_req && !dmem_valid) ? dmem_cnt + 1 : 0;
    if (dmem_req && dmem_valid && dmem_we) begin
      dmem[dmem_addr[10:3]] <= dmem_wdata;
      store_count  <= store_count + 1;
      last_st_addr <= dmem_addr;
      last_st_data <= dmem_wdata;
    end
  end

  // Handshake monitor: a request left unanswered must be held with the same payload.
  always @(negedge clk) begin
    if (reset && i_pend && !(imem_req && imem_addr == i_paddr))
      hold_err <= hold_err + 1;
    if (reset && d_pend && !(dmem_req && dmem_addr == d_paddr && dmem_wdata == d_pdata && dmem_we == d_pwe))
      hold_err <= hold_err + 1;
    i_pend  <= reset && imem_req && !imem_valid;
    d_pend  <= reset && dmem_req && !dmem_valid;
    i_paddr <= imem_addr;
    d_paddr <= dmem_addr;
    d_pdata <= dmem_wdata;
    d_pwe   <= dmem_we;
  end

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd, logic [6:0] op);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3, logic [6:0] op);
    logic [11:0] s;
    s = 12'(imm);
    return {s[11:5], 5'(rs2), 5'(rs1), 3'(f3), s[4:0], op};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3, logic [6:0] op);
    logic [12:0] b;
    b = 13'(imm);
    return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'(f3), b[4:1], b[11], op};
  endfunction

  task automatic push_ret(input logic [63:0] pc, input int lat);
    ret_t e;
    e.pc = pc;
    e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic push_reg(input int idx, input logic [63:0] val);
    reg_t r;
    r.idx = idx;
    r.val = val;
    reg_q.push_back(r);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 64'h0;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Counts edges until a retire pulse is seen; ends at the negedge of the retire cycle.
  task automatic wait_retire(input int budget, output int cyc, output bit tmo);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!retire && cyc < budget);
    tmo = !retire;
  endtask

  task automatic test_reset();
    int nz;
    clear_mem();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({imem_req, dmem_req, dmem_we, retire, halted} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got req/dreq/we/ret/halt=%b want 00000",
               {imem_req, dmem_req, dmem_we, retire, halted});
    end
    tests_run++;
    if (pc_out !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pc got %h want 0", pc_out);
    end
    nz = 0;
    for (int i = 0; i < 32; i++) begin
      dbg_sel = 5'(i);
      #1;
      if (dbg_data !== 64'h0) nz++;
    end
    tests_run++;
    if (nz !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_regs got %0d nonzero registers want 0", nz);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL first_fetch got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_alu_program();
    int cyc, total, nret;
    bit tmo;
    ret_t e;
    reg_t r;
    clear_mem();
    imem[0] = enc_i(5, 0, 0, 1, OP_IMM);      push_ret(64'h04, 4);
    imem[1] = enc_i(-3, 0, 0, 2, OP_IMM);     push_ret(64'h08, 4);
    imem[2] = enc_r(0, 2, 1, 0, 3, OP_R);     push_ret(64'h0C, 4);
    imem[3] = enc_r(32, 1, 2, 0, 4, OP_R);    push_ret(64'h10, 4);
    push_reg(1, 64'd5);
    push_reg(2, 64'hFFFF_FFFF_FFFF_FFFD);
    push_reg(3, 64'd2);
    push_reg(4, 64'hFFFF_FFFF_FFFF_FFF8);
    apply_reset();
    total = 0;
    nret = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_retire(50, cyc, tmo);
      tests_run++;
      if (tmo || cyc !== e.lat || pc_out !== e.pc) begin
        tests_failed++;
        $display("[TB] FAIL alu_retire got tmo=%0d lat=%0d pc=%h want lat=%0d pc=%h", tmo, cyc, pc_out, e.lat, e.pc);
      end
      total += cyc;
      if (!tmo) nret++;
    end
    tests_run++;
    if (total !== 16 || nret !== 4) begin
      tests_failed++;
      $display("[TB] FAIL alu_total got cycles=%0d retires=%0d want 16 and 4", total, nret);
    end
    while (reg_q.size() > 0) begin
      r = reg_q.pop_front();
      dbg_sel = 5'(r.idx);
      #1;
      tests_run++;
      if (dbg_data !== r.val) begin
        tests_failed++;
        $display("[TB] FAIL alu_reg x%0d got %h want %h", r.idx, dbg_data, r.val);
      end
    end
  endtask

  task automatic test_load_store();
    int cyc, sc0;
    bit tmo;
    ret_t e;
    reg_t r;
    clear_mem();
    imem[0] = enc_i(2, 0, 0, 3, OP_IMM);      push_ret(64'h04, 4);
    imem[1] = enc_s(8, 3, 0, 3, OP_STORE);    push_ret(64'h08, 4);
    imem[2] = enc_i(8, 0, 3, 5, OP_LOAD);     push_ret(64'h0C, 5);
    push_reg(5, 64'd2);
    sc0 = store_count;
    apply_reset();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_retire(50, cyc, tmo);
      tests_run++;
      if (tmo || cyc !== e.lat || pc_out !== e.pc) begin
        tests_failed++;
        $display("[TB] FAIL ls_retire got tmo=%0d lat=%0d pc=%h want lat=%0d pc=%h", tmo, cyc, pc_out, e.lat, e.pc);
      end
    end
    tests_run++;
    if (store_count - sc0 !== 1 || last_st_addr !== 64'd8 || last_st_data !== 64'd2) begin
      tests_failed++;
      $display("[TB] FAIL store_bus got stores=%0d addr=%h data=%h want 1 8 2",
               store_count - sc0, last_st_addr, last_st_data);
    end
    while (reg_q.size() > 0) begin
      r = reg_q.pop_front();
      dbg_sel = 5'(r.idx);
      #1;
      tests_run++;
      if (dbg_data !== r.val) begin
        tests_failed++;
        $display("[TB] FAIL ls_reg x%0d got %h want %h", r.idx, dbg_data, r.val);
      end
    end
  endtask

  task automatic test_branches();
    int cyc;
    bit tmo;
    ret_t e;
    for (int k = 0; k < 4; k++) begin
      clear_mem();
      imem[0] = enc_i(5, 0, 0, 1, OP_IMM);   push_ret(64'h04, 4);
      imem[1] = enc_i(-3, 0, 0, 2, OP_IMM);  push_ret(64'h08, 4);
      imem[2] = enc_i(0, 0, 0, 0, OP_IMM);   push_ret(64'h0C, 4);
      imem[3] = enc_i(0, 0, 0, 0, OP_IMM);   push_ret(64'h10, 4);
      imem[4] = enc_b(br_imm[k], br_rs2[k], br_rs1[k], br_f3[k], OP_BRANCH);
      push_ret(br_tgt[k], 3);
      apply_reset();
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        wait_retire(50, cyc, tmo);
        tests_run++;
        if (tmo || cyc !== e.lat || pc_out !== e.pc) begin
          tests_failed++;
          $display("[TB] FAIL branch%0d_retire got tmo=%0d lat=%0d pc=%h want lat=%0d pc=%h",
                   k, tmo, cyc, pc_out, e.lat, e.pc);
        end
      end
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== br_tgt[k]) begin
        tests_failed++;
        $display("[TB] FAIL branch%0d_fetch got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, br_tgt[k]);
      end
    end
  endtask

  task automatic test_wait_states();
    int cyc, h0;
    bit tmo;
    clear_mem();
    dmem[1] = 64'h1234_5678_9ABC_DEF0;
    imem[0] = enc_i(8, 0, 3, 5, OP_LOAD);
    push_ret(64'h04, 10);
    imem_delay = 3;
    dmem_delay = 2;
    h0 = hold_err;
    apply_reset();
    while (exp_q.size() > 0) begin
      ret_t e;
      e = exp_q.pop_front();
      wait_retire(50, cyc, tmo);
      tests_run++;
      if (tmo || cyc !== e.lat || pc_out !== e.pc) begin
        tests_failed++;
        $display("[TB] FAIL wait_ld got tmo=%0d lat=%0d pc=%h want lat=%0d pc=%h", tmo, cyc, pc_out, e.lat, e.pc);
      end
    end
    tests_run++;
    if (hold_err !== h0) begin
      tests_failed++;
      $display("[TB] FAIL req_hold got %0d unstable request cycles want 0", hold_err - h0);
    end
    dbg_sel = 5'd5;
    #1;
    tests_run++;
    if (dbg_data !== 64'h1234_5678_9ABC_DEF0) begin
      tests_failed++;
      $display("[TB] FAIL wait_ld_data got %h want 123456789abcdef0", dbg_data);
    end
    imem_delay = 0;
    dmem_delay = 0;
  endtask

  task automatic test_reset_midstore();
    int cyc, n, sc0, dreq;
    bit tmo;
    clear_mem();
    dmem[1] = 64'hDEAD_BEEF;
    imem[0] = enc_i(2, 0, 0, 3, OP_IMM);
    imem[1] = enc_s(8, 3, 0, 3, OP_STORE);
    dmem_delay = 5;
    apply_reset();
    wait_retire(50, cyc, tmo);
    n = 0;
    while (!dmem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midstore_req got req=%b we=%b want 1 1", dmem_req, dmem_we);
    end
    @(negedge clk);
    sc0 = store_count;
    reset = 1'b0;
    #1;
    tests_run++;
    if (dmem_req !== 1'b0 || imem_req !== 1'b0 || retire !== 1'b0 || pc_out !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL midstore_abort got dreq=%b ireq=%b ret=%b pc=%h want 0 0 0 0",
               dmem_req, imem_req, retire, pc_out);
    end
    dreq = 0;
    repeat (5) begin
      @(negedge clk);
      if (dmem_req || imem_req) dreq++;
    end
    tests_run++;
    if (dreq !== 0 || store_count !== sc0 || dmem[1] !== 64'hDEAD_BEEF) begin
      tests_failed++;
      $display("[TB] FAIL midstore_mem got reqcycles=%0d stores=%0d mem=%h want 0 0 deadbeef",
               dreq, store_count - sc0, dmem[1]);
    end
    dbg_sel = 5'd3;
    #1;
    tests_run++;
    if (dbg_data !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL midstore_reg x3 got %h want 0", dbg_data);
    end
    dmem_delay = 0;
  endtask

  task automatic test_x0_and_halt();
    int cyc, n, bad;
    bit tmo;
    clear_mem();
    imem[0] = enc_i(7, 0, 0, 0, OP_IMM);
    imem[1] = 32'h0000_007F;
    apply_reset();
    wait_retire(50, cyc, tmo);
    dbg_sel = 5'd0;
    #1;
    tests_run++;
    if (tmo || cyc !== 4 || dbg_data !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL x0_write got tmo=%0d lat=%0d x0=%h want lat=4 x0=0", tmo, cyc, dbg_data);
    end
    n = 0;
    while (!halted && n < 10) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (halted !== 1'b1 || n !== 2) begin
      tests_failed++;
      $display("[TB] FAIL halt_entry got halted=%b after %0d cycles want 1 after 2", halted, n);
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req || dmem_req || retire || !halted) bad++;
    end
    tests_run++;
    if (bad !== 0 || pc_out !== 64'h4) begin
      tests_failed++;
      $display("[TB] FAIL halt_hold got %0d active cycles pc=%h want 0 and pc=4", bad, pc_out);
    end
  endtask

  task automatic test_illegal_funct();
    int n, nret;
    clear_mem();
    imem[0] = enc_r(1, 1, 1, 0, 1, OP_R);
    apply_reset();
    n = 0;
    nret = 0;
    while (!halted && n < 10) begin
      @(posedge clk);
      @(negedge clk);
      if (retire) nret++;
      n++;
    end
    tests_run++;
    if (halted !== 1'b1 || n !== 2 || nret !== 0) begin
      tests_failed++;
      $display("[TB] FAIL illegal_funct got halted=%b cycles=%0d retires=%0d want 1 2 0", halted, n, nret);
    end
  endtask

  // Main sequence: each scenario resets the core and loads its own program.
  initial begin
    test_reset();
    test_alu_program();
    test_load_store();
    test_branches();
    test_wait_states();
    test_reset_midstore();
    test_x0_and_halt();
    test_illegal_funct();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/riscv_multicycle_core.md
Name: riscv_multicycle_core

Overview:
- Parametrised multi-cycle RV64-subset core; successor to the single-cycle processor top.
- Replaces combinational fetch/memory paths with a state machine and valid/request handshakes to external instruction and data memories, so memories may insert wait states.
- Adds signed branches, a halt-on-illegal mode, a retire strobe and a debug register read port.

Parameters:
- XLEN, 64, datapath/register/address width.
- NUM_REGS, 32, architectural registers (power of two, ≤32); register index = low log2(NUM_REGS) bits of the rs/rd fields.
- PC_RESET, 0, PC value loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  XLEN  fetch address (= PC).
- imem_rdata  in  32  instruction word.
- imem_valid  in  1  fetch response valid.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  XLEN  data address.
- dmem_wdata  out  XLEN  store data.
- dmem_rdata  in  XLEN  load data.
- dmem_valid  in  1  data response valid.
- pc_out  out  XLEN  current PC register.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core stopped on illegal opcode.
- dbg_sel  in  5  debug register select.
- dbg_data  out  XLEN  combinational read of register dbg_sel; x0 reads 0.

Behaviour:
- Reset (reset low, async):
  - PC=PC_RESET, all registers 0, state=FETCH.
  - imem_req, dmem_req, dmem_we, retire and halted are all 0.
  - Requests stay gated low while reset is low.
  - Reset mid-transaction abandons the access; no register write, no retire.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Handshakes:
  - A request is held high with address/data stable until the corresponding valid is seen in the same cycle.
  - The transition occurs on that edge. Valid may arrive in the request cycle (zero-wait) or later.
  - Valid while no request is active is ignored.
- FETCH: imem_req=1. On imem_valid, latch IR → DECODE.
- DECODE:
  - Latch A=R[rs1], B=R[rs2], sign-extended immediate (I/S/B formats; B-immediate includes LSB 0, no extra shift).
  - Unsupported opcode or funct → HALT.
- EXEC: ALU result → ALUOut.
  - R-type (0110011): add/sub/and/or → WB.
  - addi (0010011, f3=000) → WB.
  - ld (0000011, f3=011) and sd (0100011, f3=011): ALUOut=A+imm → MEM.
  - Branch (1100011): beq/bne/blt/bge (blt/bge signed). PC ← taken ? PC+imm : PC+4. Pulse retire → FETCH.
- MEM: dmem_req=1, dmem_addr=ALUOut, dmem_we=is_store, dmem_wdata=B.
  - On dmem_valid: store pulses retire, PC+=4 → FETCH; load latches MDR → WB.
- WB: R[rd] ← load ? MDR : ALUOut. PC+=4, pulse retire → FETCH.
- Register x0: writes to x0 are discarded.
- HALT: halted=1. No requests, no retire; exit only via reset.
- Arithmetic: all arithmetic is modulo 2^XLEN; PC wraps. No misalignment checks.
- Latency with zero-wait memory:
  - ALU/addi 4 cycles, ld 5, sd 4, branch 3.
  - Each memory wait cycle adds exactly 1.
- retire is registered and asserted only in the cycle following the completing edge.

Decomposition:
- Package riscv_pkg:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH);
  - funct3/funct7 values;
  - state enum;
  - ALU operation encoding.
- Sub-module riscv_regfile_nr:
  - NUM_REGS × XLEN;
  - 2 combinational read ports plus debug read port;
  - 1 synchronous write port;
  - x0 hardwired to 0;
  - async active-low clear.

Test Plan:
- Zero-wait memories. Program: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sub x4,x2,x1 → x3=2, x4=0xFFFF_FFFF_FFFF_FFF8, 4 retire pulses, 16 cycles total.
- sd x3,8(x0) then ld x5,8(x0) → store phase shows dmem_req=1, dmem_we=1, dmem_addr=8, dmem_wdata=2; load gives x5=2 after exactly 5 cycles.
- Branches, PC=0x10, x1=5, x2=-3:
  - beq x1,x1,+8 → next imem_addr 0x18.
  - bne x1,x1,+8 → 0x14.
  - blt x2,x1,-16 → 0x00.
  - bge x2,x1,+8 → 0x14.
- imem_valid delayed 3 cycles on fetch and dmem_valid delayed 2 on ld → requests held with stable addresses; no retire early; ld takes 5+3+2=10 cycles.
- reset driven low during sd MEM wait → dmem_req drops immediately, pc_out=PC_RESET, target memory untouched by core (no extra request), registers 0 via dbg_data.
- addi x0,x0,7 → dbg_data(0)=0. Then instruction 0x0000007F → halted=1, imem_req stays 0 for 20 cycles, no retire.
